divisor_resto: RTL

//  Sequential shift-subtract (restoring) unsigned divider. It sits directly

---
 rtl/divisor_resto.sv | 122 ++++++++++++
 1 files changed

// File: rtl/divisor_resto.sv
`default_nettype none
// ============================================================================
//  Module      : divisor_resto
//  Description : Sequential restoring (shift-subtract) unsigned divider.
//                Produces the quotient and remainder of dividendo/divisor
//                after WIDTH iterations. A one-cycle EnResto strobe loads the
//                downstream remainder register. divZero flags a zero divisor.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk        in   1      rising-edge clock
//    resetDiv   in   1      asynchronous active-low reset
//    start      in   1      division request, sampled only while idle
//    dividendo  in   WIDTH  unsigned dividend, sampled with start
//    divisor    in   WIDTH  unsigned divisor, sampled with start
//    busy       out  1      high while an operation is in progress
//    quociente  out  WIDTH  quotient of the last completed operation
//    resto      out  WIDTH  remainder of the last completed operation
//    EnResto    out  1      one-cycle strobe, results valid
//    divZero    out  1      last completed operation had a zero divisor
// ============================================================================
module divisor_resto #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             resetDiv,
    input  logic             start,
    input  logic [WIDTH-1:0] dividendo,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic [WIDTH-1:0] quociente,
    output logic [WIDTH-1:0] resto,
    output logic             EnResto,
    output logic             divZero
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // Counter value on the edge that performs the final iteration.
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    logic [1:0]       state;
    logic [WIDTH:0]   rem;        // partial remainder, one guard bit
    logic [WIDTH-1:0] shq;        // dividend shifting out / quotient shifting in
    logic [WIDTH-1:0] dvs;        // latched divisor
    logic [CW-1:0]    cnt;

    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   rem_next;
    logic [WIDTH-1:0] q_next;
    logic             fits;

    // One restoring step: shift the next dividend bit into the remainder
    // and subtract the divisor when it fits. The guard bit keeps the compare
    // correct for divisors at or above 2^(WIDTH-1).
    always_comb begin
        rem_shift = (rem << 1) | {{WIDTH{1'b0}}, shq[WIDTH-1]};
        fits      = (rem_shift >= {1'b0, dvs});
        rem_next  = fits ? (rem_shift - {1'b0, dvs}) : rem_shift;
        q_next    = {shq[WIDTH-2:0], fits};
    end

    always_ff @(posedge clk or negedge resetDiv) begin
        if (!resetDiv) begin
            state     <= IDLE;
            rem       <= '0;
            shq       <= '0;
            dvs       <= '0;
            cnt       <= '0;
            quociente <= '0;
            resto     <= '0;
            divZero   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        dvs <= divisor;
                        rem <= '0;
                        shq <= dividendo;
                        cnt <= '0;
                        if (divisor == '0) begin
                            // Zero divisor: results are defined directly,
                            // no iterations are spent.
                            quociente <= '1;
                            resto     <= dividendo;
                            divZero   <= 1'b1;
                            state     <= DONE;
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    rem <= rem_next;
                    shq <= q_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST_ITER) begin
                        quociente <= q_next;
                        resto     <= rem_next[WIDTH-1:0];
                        divZero   <= 1'b0;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy    = (state != IDLE);
    assign EnResto = (state == DONE);

endmodule
`default_nettype wire
